coprocessor_controller: RTL and testbench
=========================================

Name: coprocessor_controller

Overview:
- Command sequencer in front of the matrix ALU: `alu`, with 5x5 int8 matrices packed into 200-bit flat words.
- Accepts 32-bit instruction words from the host bus over a valid/ready handshake.
- Holds the A, B and result matrix banks, and launches ALU operations with a stable opcode.
- Waits for the ALU `done` signal with a timeout, then captures `C_flat`, `number` and `overflow_flag` for host readback.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before an error abort.
- ELEM_W, 8: element width in bits.
- N_MAX, 5: matrix dimension; flat word width is N_MAX*N_MAX*ELEM_W = 200.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word. Fields: [31:29] cmd, [28] bank sel (0=A, 1=B), [27:25] row, [24:22] col, [21:19] alu opcode, [18:16] size, [15:8] scalar, [7:0] data.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- resp_data  out  8  readback byte.
- resp_valid  out  1  one-cycle pulse qualifying resp_data.
- exec_done  out  1  one-cycle pulse when a result has been captured.
- busy  out  1  high in every state other than IDLE.
- overflow  out  1  overflow_flag from the last completed EXEC.
- error  out  1  sticky error flag.
- alu_A_flat  out  200  to ALU `A_flat`.
- alu_B_flat  out  200  to ALU `B_flat`.
- alu_opcode  out  3  to ALU; 000 when not executing.
- alu_matrix_size  out  3  to ALU `matrix_size`.
- alu_scalar  out  8  to ALU `scalar`.
- alu_C_flat  in  200  ALU result matrix.
- alu_number  in  8  ALU determinant result.
- alu_overflow  in  1  ALU overflow flag.
- alu_done  in  1  ALU completion.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; A, B and C banks are zeroed.
  - All outputs go to 0 except instr_ready, which is 1.
  - Reset mid-operation aborts the operation immediately; no exec_done is produced.
- Element addressing: element (row, col) occupies flat bits [(row*5+col)*8 +: 8]. Row or col > 4 sets error and the instruction is dropped.
- Handshake: an instruction is accepted on a clock edge with instr_valid && instr_ready. instr_ready = 1 only in IDLE.
- Commands (cmd field):
  - 000 NOP: no effect.
  - 001 LOAD: writes data into the selected bank at (row, col); the new value is visible on alu_*_flat the next cycle.
  - 010 EXEC: see the EXEC rules below.
  - 011 READ: resp_data = C[row][col]; resp_valid pulses the cycle after accept.
  - 100 READ_NUM: resp_data = captured number; resp_valid pulses the cycle after accept.
  - 101 CLEAR: zeroes A, B, C, number, overflow and error.
  - 110 and 111: illegal; set error (110 is reserved for the optional feature).
- EXEC rules:
  - Valid only when size is 2..5 and opcode != 000. Otherwise set error, remain in IDLE, and leave alu_opcode unchanged.
  - On a valid EXEC, latch opcode, size and scalar into registers, then enter ISSUE.
- State machine:
  - IDLE -> ISSUE on a valid EXEC.
  - ISSUE (1 cycle): alu_opcode held at 000 so that a stale done is flushed; matrix_size and scalar are already driven. -> WAIT.
  - WAIT: alu_opcode = latched opcode and the cycle counter increments from 1.
    - alu_done is ignored in the first WAIT cycle.
    - alu_done=1 on a later cycle -> CAPTURE.
    - Counter reaching TIMEOUT_CYCLES without done -> set error, alu_opcode = 000, -> IDLE, no exec_done.
    - If done and timeout occur in the same cycle, done wins.
  - CAPTURE (1 cycle): C <= alu_C_flat, number <= alu_number, overflow <= alu_overflow; exec_done pulses; alu_opcode = 000. -> IDLE.
- Operand usage: opcodes 100, 101, 110 and 111 use A only; B is still driven unchanged.
- Other rules:
  - The A and B banks cannot change while busy, because instr_ready = 0.
  - error clears only on CLEAR or reset.
  - overflow updates only in CAPTURE.

Optional Feature:
- Macro CHAIN_RESULT_EN.
- Defined: cmd 110 MOVE copies the C bank into the A bank in one cycle, accepted only in IDLE, so that operations can be chained.
- Undefined: cmd 110 is illegal and sets error.

Decomposition:
- Package coprocessor_pkg holds:
  - cmd encodings;
  - ALU opcode encodings (001 add, 010 sub, 011 mul, 100 opposite, 101 transpose, 110 scalar, 111 determinant);
  - FSM state enum (IDLE, ISSUE, WAIT, CAPTURE);
  - instruction field bit positions;
  - N_MAX and ELEM_W.
- One sub-module, matrix_bank: a 25x8 register file with a single-element write port, a whole-word load port, synchronous clear, asynchronous reset and a flat 200-bit output. Instantiated for A, B and C.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> all outputs 0 and instr_ready=1; after release, alu_A_flat = 0.
- LOAD and add:
  - Stimulus: LOAD A elements 1, 2, 3, 4 and B elements 02, 05, FF, 01 at (0,0), (0,1), (1,0), (1,1); EXEC add size 2; ALU model returns done 2 cycles after opcode is seen.
  - Response: alu_A_flat bytes 0, 1, 5, 6 = 01, 02, 03, 04; exec_done pulses once; READ (0,0) returns 03 with resp_valid exactly 1 cycle after accept.
- Bad EXEC: EXEC with size 6, or with opcode 000 -> error=1, state stays IDLE, alu_opcode stays 000, instr_ready stays 1.
- Timeout: ALU model never asserts done -> error=1 after exactly 64 WAIT cycles, alu_opcode returns to 000, exec_done never pulses, then CLEAR -> error=0.
- Determinant: load a 3x3 identity, EXEC 111 with the model returning number=01 after 5 cycles -> READ_NUM gives 01, overflow=0; a model returning alu_overflow=1 gives overflow=1.
- Reset in WAIT: drop reset_n in the third WAIT cycle -> busy=0, banks zero in the same cycle, and no exec_done. With CHAIN_RESULT_EN: MOVE then READ of A via EXEC opposite yields -C.

Source files
------------

// File: rtl/coprocessor_pkg.sv
// Shared encodings for the matrix-ALU command sequencer: commands, ALU opcodes,
// FSM states, instruction field positions and matrix geometry.
package coprocessor_pkg;

    localparam int ELEM_W = 8;
    localparam int N_MAX  = 5;
    localparam int N_ELEM = N_MAX * N_MAX;
    localparam int FLAT_W = N_ELEM * ELEM_W;
    localparam int IDX_W  = 5;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'b000,
        CMD_LOAD     = 3'b001,
        CMD_EXEC     = 3'b010,
        CMD_READ     = 3'b011,
        CMD_READ_NUM = 3'b100,
        CMD_CLEAR    = 3'b101,
        CMD_MOVE     = 3'b110,
        CMD_ILLEGAL  = 3'b111
    } cmd_e;

    localparam logic [2:0] OP_NONE      = 3'b000;
    localparam logic [2:0] OP_ADD       = 3'b001;
    localparam logic [2:0] OP_SUB       = 3'b010;
    localparam logic [2:0] OP_MUL       = 3'b011;
    localparam logic [2:0] OP_OPPOSITE  = 3'b100;
    localparam logic [2:0] OP_TRANSPOSE = 3'b101;
    localparam logic [2:0] OP_SCALAR    = 3'b110;
    localparam logic [2:0] OP_DET       = 3'b111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    localparam int CMD_MSB    = 31;
    localparam int CMD_LSB    = 29;
    localparam int BANK_BIT   = 28;
    localparam int ROW_MSB    = 27;
    localparam int ROW_LSB    = 25;
    localparam int COL_MSB    = 24;
    localparam int COL_LSB    = 22;
    localparam int OPC_MSB    = 21;
    localparam int OPC_LSB    = 19;
    localparam int SIZE_MSB   = 18;
    localparam int SIZE_LSB   = 16;
    localparam int SCALAR_MSB = 15;
    localparam int SCALAR_LSB = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    typedef struct packed {
        cmd_e              cmd;
        logic              bank;
        logic [2:0]        row;
        logic [2:0]        col;
        logic [2:0]        opc;
        logic [2:0]        size;
        logic [ELEM_W-1:0] scalar;
        logic [ELEM_W-1:0] data;
    } instr_t;

    function automatic instr_t decode(input logic [31:0] w);
        instr_t f;
        f.cmd    = cmd_e'(w[CMD_MSB:CMD_LSB]);
        f.bank   = w[BANK_BIT];
        f.row    = w[ROW_MSB:ROW_LSB];
        f.col    = w[COL_MSB:COL_LSB];
        f.opc    = w[OPC_MSB:OPC_LSB];
        f.size   = w[SIZE_MSB:SIZE_LSB];
        f.scalar = w[SCALAR_MSB:SCALAR_LSB];
        f.data   = w[DATA_MSB:DATA_LSB];
        return f;
    endfunction

    // Row-major element index; only meaningful when row and col are both < N_MAX.
    function automatic logic [IDX_W-1:0] elem_idx(input logic [2:0] row, input logic [2:0] col);
        return IDX_W'(row) * IDX_W'(N_MAX) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// 25 x int8 register file with single-element write, whole-word load,
// synchronous clear and a flat 200-bit read view.
module matrix_bank
    import coprocessor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [FLAT_W-1:0] load_data_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [ELEM_W-1:0] wdata_i,
    output logic [FLAT_W-1:0] flat_o
);

    logic [ELEM_W-1:0] mem_q [N_ELEM];

    // NOTE: the banks must read as zero straight out of reset, so this array is
    // built from resettable flops rather than an unreset RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) begin
                // NOTE: sequential state is always assigned with <= so every flop
                // samples the pre-edge values regardless of statement order.
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem_q[i] <= load_data_i[i*ELEM_W +: ELEM_W];
            end
        end else if (we_i && (idx_i < IDX_W'(N_ELEM))) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_comb begin
        for (int i = 0; i < N_ELEM; i++) begin
            flat_o[i*ELEM_W +: ELEM_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/coprocessor_controller.sv
// Command sequencer in front of the matrix ALU. Define CHAIN_RESULT_EN to turn
// command 110 into MOVE (C bank -> A bank); otherwise 110 is illegal.
module coprocessor_controller
    import coprocessor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [7:0]        resp_data,
    output logic              resp_valid,
    output logic              exec_done,
    output logic              busy,
    output logic              overflow,
    output logic              error,
    output logic [FLAT_W-1:0] alu_A_flat,
    output logic [FLAT_W-1:0] alu_B_flat,
    output logic [2:0]        alu_opcode,
    output logic [2:0]        alu_matrix_size,
    output logic [7:0]        alu_scalar,
    input  logic [FLAT_W-1:0] alu_C_flat,
    input  logic [7:0]        alu_number,
    input  logic              alu_overflow,
    input  logic              alu_done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state_q,     state_d;
    logic [2:0]       opc_q,       opc_d;
    logic [2:0]       size_q,      size_d;
    logic [7:0]       scalar_q,    scalar_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       number_q,    number_d;
    logic             ovf_q,       ovf_d;
    logic             err_q,       err_d;
    logic [7:0]       resp_data_q, resp_data_d;
    logic             resp_valid_q, resp_valid_d;

    logic              clear_all, a_we, b_we, a_load, c_load;
    logic [FLAT_W-1:0] c_flat;
    logic [IDX_W-1:0]  idx;
    logic              coord_ok, exec_ok, accept;
    instr_t            f;

    assign f        = decode(instr);
    assign idx      = elem_idx(f.row, f.col);
    assign coord_ok = (f.row < 3'(N_MAX)) && (f.col < 3'(N_MAX));
    assign exec_ok  = (f.size >= 3'd2) && (f.size <= 3'(N_MAX)) && (f.opc != OP_NONE);
    assign accept   = instr_valid && instr_ready;

    matrix_bank u_bank_a (
        .clk        (clock),
        .rst_n      (reset_n),
        .clear_i    (clear_all),
        .load_i     (a_load),
        .load_data_i(c_flat),
        .we_i       (a_we),
        .idx_i      (idx),
        .wdata_i    (f.data),
        .flat_o     (alu_A_flat)
    );

    matrix_bank u_bank_b (
        .clk        (clock),
        .rst_n      (reset_n),
        .clear_i    (clear_all),
        .load_i     (1'b0),
        .load_data_i('0),
        .we_i       (b_we),
        .idx_i      (idx),
        .wdata_i    (f.data),
        .flat_o     (alu_B_flat)
    );

    matrix_bank u_bank_c (
        .clk        (clock),
        .rst_n      (reset_n),
        .clear_i    (clear_all),
        .load_i     (c_load),
        .load_data_i(alu_C_flat),
        .we_i       (1'b0),
        .idx_i      ('0),
        .wdata_i    ('0),
        .flat_o     (c_flat)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        opc_d        = opc_q;
        size_d       = size_q;
        scalar_d     = scalar_q;
        cnt_d        = cnt_q;
        number_d     = number_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        clear_all    = 1'b0;
        a_we         = 1'b0;
        b_we         = 1'b0;
        a_load       = 1'b0;
        c_load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (f.cmd)
                        CMD_NOP: ;
                        CMD_LOAD: begin
                            if (coord_ok) begin
                                a_we = !f.bank;
                                b_we = f.bank;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_EXEC: begin
                            if (exec_ok) begin
                                opc_d    = f.opc;
                                size_d   = f.size;
                                scalar_d = f.scalar;
                                state_d  = ST_ISSUE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            if (coord_ok) begin
                                resp_data_d  = c_flat[int'(idx)*ELEM_W +: ELEM_W];
                                resp_valid_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_READ_NUM: begin
                            resp_data_d  = number_q;
                            resp_valid_d = 1'b1;
                        end
                        CMD_CLEAR: begin
                            clear_all = 1'b1;
                            number_d  = '0;
                            ovf_d     = 1'b0;
                            err_d     = 1'b0;
                        end
`ifdef CHAIN_RESULT_EN
                        CMD_MOVE: a_load = 1'b1;
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            // Opcode stays at 000 for this cycle so a done left over from a
            // previous operation drops before the real launch.
            ST_ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done && (cnt_q != CNT_W'(1))) begin
                    state_d = ST_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                c_load   = 1'b1;
                number_d = alu_number;
                ovf_d    = alu_overflow;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            opc_q        <= OP_NONE;
            size_q       <= '0;
            scalar_q     <= '0;
            cnt_q        <= '0;
            number_q     <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            opc_q        <= opc_d;
            size_q       <= size_d;
            scalar_q     <= scalar_d;
            cnt_q        <= cnt_d;
            number_q     <= number_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign instr_ready     = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign exec_done       = (state_q == ST_CAPTURE);
    assign alu_opcode      = (state_q == ST_WAIT) ? opc_q : OP_NONE;
    assign alu_matrix_size = size_q;
    assign alu_scalar      = scalar_q;
    assign overflow        = ovf_q;
    assign error           = err_q;
    assign resp_data       = resp_data_q;
    assign resp_valid      = resp_valid_q;

endmodule

// File: tb/tb_coprocessor_controller.sv
// Scoreboard bench for coprocessor_controller: directed instructions, a small
// ALU responder model, and a monitor that pops expected responses.
module tb_coprocessor_controller;

    localparam int FW = 200;

    logic          clock;
    logic          reset_n;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [7:0]    resp_data;
    logic          resp_valid;
    logic          exec_done;
    logic          busy;
    logic          overflow;
    logic          error;
    logic [FW-1:0] alu_A_flat;
    logic [FW-1:0] alu_B_flat;
    logic [2:0]    alu_opcode;
    logic [2:0]    alu_matrix_size;
    logic [7:0]    alu_scalar;
    logic [FW-1:0] alu_C_flat;
    logic [7:0]    alu_number;
    logic          alu_overflow;
    logic          alu_done;

    coprocessor_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .resp_data      (resp_data),
        .resp_valid     (resp_valid),
        .exec_done      (exec_done),
        .busy           (busy),
        .overflow       (overflow),
        .error          (error),
        .alu_A_flat     (alu_A_flat),
        .alu_B_flat     (alu_B_flat),
        .alu_opcode     (alu_opcode),
        .alu_matrix_size(alu_matrix_size),
        .alu_scalar     (alu_scalar),
        .alu_C_flat     (alu_C_flat),
        .alu_number     (alu_number),
        .alu_overflow   (alu_overflow),
        .alu_done       (alu_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
        string      name;
    } resp_t;

    resp_t resp_q[$];
    int    exec_pending = 0;

    // ALU responder: raises done once the opcode has been visible for model_lat cycles.
    int            model_lat = -1;
    int            seen = 0;
    logic [FW-1:0] model_C = '0;
    logic [7:0]    model_number = '0;
    logic          model_ovf = 1'b0;

    assign alu_C_flat   = model_C;
    assign alu_number   = model_number;
    assign alu_overflow = model_ovf;

    initial begin
        alu_done = 1'b0;
        forever begin
            @(negedge clock);
            if (alu_opcode != 3'b000) seen++;
            else seen = 0;
            alu_done = (model_lat > 0) && (seen >= model_lat);
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every response and every exec_done must match a pending expectation.
    always @(negedge clock) begin
        resp_t e;
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got data %0h, required no response", resp_data);
            end else begin
                e = resp_q.pop_front();
                check({e.name, "_data"}, resp_data, e.data);
                check({e.name, "_latency"}, cyc, e.due);
            end
        end
        if (exec_done) begin
            check("exec_done_expected", exec_pending > 0, 1);
            if (exec_pending > 0) exec_pending--;
        end
    end

    function automatic logic [31:0] ld(input logic bank, input logic [2:0] row, input logic [2:0] col,
                                       input logic [7:0] data);
        return {3'b001, bank, row, col, 3'b000, 3'b000, 8'h00, data};
    endfunction

    function automatic logic [31:0] ex(input logic [2:0] opc, input logic [2:0] size, input logic [7:0] scalar);
        return {3'b010, 1'b0, 3'd0, 3'd0, opc, size, scalar, 8'h00};
    endfunction

    function automatic logic [31:0] rd(input logic [2:0] row, input logic [2:0] col);
        return {3'b011, 1'b0, row, col, 3'b000, 3'b000, 8'h00, 8'h00};
    endfunction

    localparam logic [31:0] I_READ_NUM = 32'h8000_0000;
    localparam logic [31:0] I_CLEAR    = 32'hA000_0000;
    localparam logic [31:0] I_MOVE     = 32'hC000_0000;
    localparam logic [31:0] I_ILL7     = 32'hE000_0000;

    task automatic issue(input logic [31:0] w, input bit has_resp = 1'b0,
                         input logic [7:0] exp = 8'h00, input string name = "");
        resp_t e;
        int    budget;
        @(negedge clock);
        budget = 0;
        while (!instr_ready && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (!instr_ready) check("issue_ready_timeout", instr_ready, 1);
        if (has_resp) begin
            e.data = exp;
            e.due  = cyc + 1;
            e.name = name;
            resp_q.push_back(e);
        end
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        @(negedge clock);
        while (busy && budget < 300) begin
            @(negedge clock);
            budget++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] exp_a;
        logic [FW-1:0] exp_b;
        logic [FW-1:0] c_add;
        int            wait_cnt;

        instr       = '0;
        instr_valid = 1'b0;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_instr_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_exec_done", exec_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_error", error, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_alu_size", alu_matrix_size, 0);
        check("rst_alu_scalar", alu_scalar, 0);
        check("rst_alu_B", alu_B_flat, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_alu_A", alu_A_flat, 0);

        // Bad EXEC: size 6, opcode 000, size 1
        issue(ex(3'b001, 3'd6, 8'h00));
        @(negedge clock);
        check("bad_size_error", error, 1);
        check("bad_size_busy", busy, 0);
        check("bad_size_opcode", alu_opcode, 0);
        check("bad_size_ready", instr_ready, 1);
        issue(I_CLEAR);
        @(negedge clock);
        check("clear_error", error, 0);
        issue(ex(3'b000, 3'd2, 8'h00));
        @(negedge clock);
        check("bad_opc_error", error, 1);
        check("bad_opc_busy", busy, 0);
        issue(I_CLEAR);
        issue(ex(3'b001, 3'd1, 8'h00));
        @(negedge clock);
        check("bad_size1_error", error, 1);
        issue(I_CLEAR);

        // Out-of-range LOAD is dropped; illegal command 111
        issue(ld(1'b0, 3'd5, 3'd0, 8'hAA));
        @(negedge clock);
        check("bad_row_error", error, 1);
        check("bad_row_A_unchanged", alu_A_flat, 0);
        issue(I_CLEAR);
        issue(ld(1'b1, 3'd0, 3'd5, 8'hAA));
        @(negedge clock);
        check("bad_col_error", error, 1);
        check("bad_col_B_unchanged", alu_B_flat, 0);
        issue(I_CLEAR);
        issue(I_ILL7);
        @(negedge clock);
        check("cmd111_error", error, 1);
        issue(I_CLEAR);

        // LOAD A/B and EXEC add, size 2
        issue(ld(1'b0, 3'd0, 3'd0, 8'h01));
        @(negedge clock);
        exp_a = '0;
        exp_a[7:0] = 8'h01;
        check("load_visible_next_cycle", alu_A_flat, exp_a);
        issue(ld(1'b0, 3'd0, 3'd1, 8'h02));
        issue(ld(1'b0, 3'd1, 3'd0, 8'h03));
        issue(ld(1'b0, 3'd1, 3'd1, 8'h04));
        issue(ld(1'b1, 3'd0, 3'd0, 8'h02));
        issue(ld(1'b1, 3'd0, 3'd1, 8'h05));
        issue(ld(1'b1, 3'd1, 3'd0, 8'hFF));
        issue(ld(1'b1, 3'd1, 3'd1, 8'h01));
        @(negedge clock);
        exp_a[15:8]  = 8'h02;
        exp_a[47:40] = 8'h03;
        exp_a[55:48] = 8'h04;
        exp_b = '0;
        exp_b[7:0]   = 8'h02;
        exp_b[15:8]  = 8'h05;
        exp_b[47:40] = 8'hFF;
        exp_b[55:48] = 8'h01;
        check("bank_A", alu_A_flat, exp_a);
        check("bank_B", alu_B_flat, exp_b);

        c_add = '0;
        c_add[7:0]   = 8'h03;
        c_add[15:8]  = 8'h07;
        c_add[47:40] = 8'h02;
        c_add[55:48] = 8'h05;
        model_C      = c_add;
        model_number = 8'h00;
        model_ovf    = 1'b0;
        model_lat    = 2;
        exec_pending++;
        issue(ex(3'b001, 3'd2, 8'h09));
        @(negedge clock);
        check("issue_opcode_zero", alu_opcode, 0);
        check("issue_size_driven", alu_matrix_size, 2);
        check("issue_scalar_driven", alu_scalar, 8'h09);
        check("issue_busy", busy, 1);
        check("issue_ready_low", instr_ready, 0);
        @(negedge clock);
        check("wait_opcode", alu_opcode, 3'b001);
        wait_idle("add_complete");
        check("add_error", error, 0);
        check("add_overflow", overflow, 0);
        check("add_opcode_idle", alu_opcode, 0);
        issue(rd(3'd0, 3'd0), 1'b1, 8'h03, "read_00");
        issue(rd(3'd1, 3'd0), 1'b1, 8'h02, "read_10");
        issue(rd(3'd1, 3'd1), 1'b1, 8'h05, "read_11");
        issue(rd(3'd4, 3'd4), 1'b1, 8'h00, "read_44");

`ifdef CHAIN_RESULT_EN
        issue(I_MOVE);
        @(negedge clock);
        check("move_A_is_C", alu_A_flat, c_add);
        check("move_no_error", error, 0);
`else
        issue(I_MOVE);
        @(negedge clock);
        check("cmd110_error", error, 1);
        check("cmd110_A_unchanged", alu_A_flat, exp_a);
`endif
        issue(rd(3'd0, 3'd5));
        @(negedge clock);
        check("bad_read_error", error, 1);
        issue(I_CLEAR);
        @(negedge clock);
        check("clear_A", alu_A_flat, 0);
        check("clear_error2", error, 0);

        // Timeout: ALU never answers
        model_lat = -1;
        issue(ex(3'b011, 3'd4, 8'h00));
        @(negedge clock);
        check("to_issue_opcode", alu_opcode, 0);
        wait_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (busy && alu_opcode == 3'b011) wait_cnt++;
        end
        check("to_wait_cycles", wait_cnt, 64);
        check("to_error_not_yet", error, 0);
        @(negedge clock);
        check("to_error", error, 1);
        check("to_opcode", alu_opcode, 0);
        check("to_busy", busy, 0);
        issue(I_CLEAR);
        @(negedge clock);
        check("to_clear_error", error, 0);

        // Done arriving in the 64th WAIT cycle beats the timeout
        model_C   = '0;
        model_lat = 64;
        exec_pending++;
        issue(ex(3'b110, 3'd2, 8'h03));
        wait_idle("late_done_complete");
        check("late_done_no_error", error, 0);

        // Determinant of a 3x3 identity
        issue(ld(1'b0, 3'd0, 3'd0, 8'h01));
        issue(ld(1'b0, 3'd1, 3'd1, 8'h01));
        issue(ld(1'b0, 3'd2, 3'd2, 8'h01));
        @(negedge clock);
        exp_a = '0;
        exp_a[7:0]    = 8'h01;
        exp_a[55:48]  = 8'h01;
        exp_a[103:96] = 8'h01;
        check("ident_A", alu_A_flat, exp_a);
        model_number = 8'h01;
        model_ovf    = 1'b0;
        model_lat    = 5;
        exec_pending++;
        issue(ex(3'b111, 3'd3, 8'h00));
        wait_idle("det_complete");
        check("det_overflow", overflow, 0);
        issue(I_READ_NUM, 1'b1, 8'h01, "read_num_det");

        model_number = 8'h80;
        model_ovf    = 1'b1;
        exec_pending++;
        issue(ex(3'b111, 3'd5, 8'h00));
        @(negedge clock);
        check("det5_size", alu_matrix_size, 5);
        check("det5_overflow_before_capture", overflow, 0);
        wait_idle("det5_complete");
        check("det5_overflow", overflow, 1);
        issue(I_READ_NUM, 1'b1, 8'h80, "read_num_ovf");

        // Reset during the third WAIT cycle
        issue(ld(1'b0, 3'd0, 3'd0, 8'h55));
        @(negedge clock);
        check("pre_rst_A_byte0", alu_A_flat[7:0], 8'h55);
        model_lat = -1;
        issue(ex(3'b001, 3'd2, 8'h00));
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("rstwait_busy", busy, 0);
        check("rstwait_A", alu_A_flat, 0);
        check("rstwait_B", alu_B_flat, 0);
        check("rstwait_opcode", alu_opcode, 0);
        check("rstwait_overflow", overflow, 0);
        check("rstwait_ready", instr_ready, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        issue(rd(3'd0, 3'd0), 1'b1, 8'h00, "read_C_after_rst");
        repeat (4) @(negedge clock);

        check("resp_queue_drained", resp_q.size(), 0);
        check("exec_done_all_seen", exec_pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
